lcm_32: RTL and testbench
=========================

LCM_32 -- requirements
Module: lcm_32

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port ina, input, 32 bits: operand A, unsigned.
REQ-004 SHALL have port inb, input, 32 bits: operand B, unsigned.
REQ-005 SHALL have port result, output, 64 bits: unsigned least common multiple lcm(A,B).
REQ-006 SHALL have port ready_n, output, 1 bit: active-low result-valid flag.
REQ-007 SHALL have no parameters; operand width is fixed at 32 bits and result width at 64 bits.

Function
REQ-008 SHALL capture ina and inb into internal registers on the first rising clk edge with rst low; later changes to ina or inb SHALL be ignored until the next reset.
REQ-009 SHALL sequence through the states IDLE, GCD, DIV, MUL, DONE, in that order.
- IDLE: load operands.
- GCD: g = gcd(A,B).
- DIV: q = A/g.
- MUL: result = q*B.
- DONE: hold the result.
REQ-010 SHALL compute the GCD with the binary (Stein) algorithm:
- shift out common factors of 2 and count them;
- strip remaining factors of 2 from each operand;
- subtract the smaller operand from the larger until they are equal;
- restore the common power of 2.
REQ-011 SHALL perform DIV as 32-cycle restoring division, and MUL as 32-cycle shift-and-add producing the full 64-bit product.
REQ-012 SHALL produce the exact result; lcm of two 32-bit values always fits in 64 bits, so no overflow or truncation is permitted.
REQ-013 SHALL, if A=0 or B=0, skip GCD, DIV and MUL, go straight to DONE with result=0, and assert ready_n low within 2 cycles.
REQ-014 SHALL hold result at 0 and ready_n at 1 in every state except DONE.
REQ-015 SHALL, in DONE, drive the final result and ready_n=0 in the same cycle, and hold both stable until rst is asserted.
REQ-016 SHALL assert ready_n low no more than 256 clk cycles after the first cycle with rst low, for any operand pair.
REQ-017 SHALL not auto-restart from DONE; a new computation requires a reset pulse.

Reset
REQ-018 SHALL, on any rising clk edge with rst=1:
- enter IDLE;
- set result=0 and ready_n=1;
- clear all internal registers.
REQ-019 SHALL abort any in-progress computation when rst is asserted in any state, with no partial result visible.
REQ-020 SHALL restart cleanly with freshly captured operands after rst deasserts, regardless of when reset occurred.

Structure
REQ-021 SHALL place the GCD datapath in one sub-module, gcd_32:
- inputs: clk, rst, two 32-bit operands;
- outputs: 32-bit gcd and an active-low done flag.
REQ-022 SHALL keep the DIV/MUL datapath and the top-level state machine in lcm_32.
REQ-023 SHALL use no shared package; state encodings are local constants of lcm_32.

Verification
REQ-024 SHALL check ina=640, inb=120, rst released -> ready_n falls within 256 cycles, result=1920.
REQ-025 SHALL check ina=2502, inb=122 after a fresh reset -> result=152622 (gcd 2).
REQ-026 SHALL check ina=1402, inb=291 -> result=407982 (coprime, equals product).
REQ-027 SHALL check ina=0xFFFFFFFF, inb=0xFFFFFFFE -> result=0xFFFFFFFD00000002 within 256 cycles, and ina=0, inb=5 -> result=0, ready_n=0.
REQ-028 SHALL check a computation on 640/120 with rst asserted mid-GCD and operands changed to 7/5 -> result stays 0 and ready_n stays 1 during reset, then result=35.
REQ-029 SHALL check that ina and inb changed while in DONE -> result and ready_n stay unchanged until the next reset.

Source files
------------

// File: rtl/gcd_32.sv
// gcd_32 -- binary (Stein) greatest common divisor of two 32-bit unsigned values.
//
// The unit starts on the first clock edge with rst low: it loads the operands,
// shifts out and counts their common factors of 2, then repeatedly strips
// single factors of 2 or halves the difference of two odd values until both
// are equal. The common power of 2 is restored in the final step. One
// operation per cycle, so the loop needs at most about 64 cycles for
// nonzero operands.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset; holding it high keeps the unit idle
//   opa_i    : operand A (must be stable while the unit runs)
//   opb_i    : operand B (must be stable while the unit runs)
//   gcd_o    : gcd(A,B), valid while done_n_o is low
//   done_n_o : active-low completion flag, held low until the next reset
module gcd_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  output logic [31:0] gcd_o,
  output logic        done_n_o
);

  typedef enum logic [1:0] {
    G_LOAD,
    G_COMMON,
    G_REDUCE,
    G_DONE
  } gstate_t;

  gstate_t     state_q;
  logic [31:0] x_q;
  logic [31:0] y_q;
  logic [4:0]  k_q;
  logic [31:0] gcd_q;
  logic        done_n_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= G_LOAD;
      x_q      <= '0;
      y_q      <= '0;
      k_q      <= '0;
      gcd_q    <= '0;
      done_n_q <= 1'b1;
    end else begin
      case (state_q)
        G_LOAD: begin
          x_q <= opa_i;
          y_q <= opb_i;
          k_q <= '0;
          // A zero operand would never leave the shift loop; gcd(x,0) = x.
          if (opa_i == '0 || opb_i == '0) begin
            gcd_q    <= opa_i | opb_i;
            done_n_q <= 1'b0;
            state_q  <= G_DONE;
          end else begin
            state_q <= G_COMMON;
          end
        end

        G_COMMON: begin
          if (!x_q[0] && !y_q[0]) begin
            x_q <= x_q >> 1;
            y_q <= y_q >> 1;
            k_q <= k_q + 5'd1;
          end else begin
            state_q <= G_REDUCE;
          end
        end

        G_REDUCE: begin
          // Difference of two odd values is even, so halving it is exact
          // and keeps gcd unchanged once the common 2s are gone.
          if (!x_q[0]) begin
            x_q <= x_q >> 1;
          end else if (!y_q[0]) begin
            y_q <= y_q >> 1;
          end else if (x_q == y_q) begin
            gcd_q    <= x_q << k_q;
            done_n_q <= 1'b0;
            state_q  <= G_DONE;
          end else if (x_q > y_q) begin
            x_q <= (x_q - y_q) >> 1;
          end else begin
            y_q <= (y_q - x_q) >> 1;
          end
        end

        G_DONE: begin
          state_q <= G_DONE;
        end

        default: begin
          state_q <= G_LOAD;
        end
      endcase
    end
  end

  assign gcd_o    = gcd_q;
  assign done_n_o = done_n_q;

endmodule

// File: rtl/lcm_32.sv
// lcm_32 -- least common multiple of two 32-bit unsigned operands.
//
// Operands are captured on the first clock edge after reset is released and
// then ignored until the next reset. The result is lcm = (A / gcd(A,B)) * B,
// computed as: GCD (gcd_32 sub-module), 32-cycle restoring division, and
// 32-cycle shift-and-add multiply to a full 64-bit product. A zero operand
// short-circuits to result 0. The result is held until the next reset; there
// is no automatic restart.
//
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset, aborts any computation
//   ina     : operand A, unsigned 32 bits
//   inb     : operand B, unsigned 32 bits
//   result  : lcm(A,B), 64 bits; 0 until the computation is done
//   ready_n : active-low result-valid flag
module lcm_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ina,
  input  logic [31:0] inb,
  output logic [63:0] result,
  output logic        ready_n
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GCD,
    ST_DIV,
    ST_MUL,
    ST_DONE
  } state_t;

  state_t      state_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] g_q;
  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [4:0]  cnt_q;
  logic [63:0] mcand_q;
  logic [31:0] mplier_q;
  logic [63:0] prod_q;
  logic [63:0] result_q;
  logic        ready_n_q;

  logic        gcd_rst;
  logic [31:0] gcd_val;
  logic        gcd_done_n;

  logic [32:0] rem_sh_d;
  logic        rem_ge_d;
  logic [31:0] rem_d;
  logic [31:0] quo_d;
  logic [63:0] prod_d;

  // The GCD unit is held in reset outside the GCD state, so it starts fresh
  // from the captured operands each time the state is entered.
  assign gcd_rst = rst || (state_q != ST_GCD);

  gcd_32 u_gcd (
    .clk      (clk),
    .rst      (gcd_rst),
    .opa_i    (a_q),
    .opb_i    (b_q),
    .gcd_o    (gcd_val),
    .done_n_o (gcd_done_n)
  );

  // Restoring division step: shift the next dividend bit into the partial
  // remainder and subtract the divisor when it fits. rem < g always, so the
  // shifted remainder needs one extra bit only transiently.
  assign rem_sh_d = {rem_q, quo_q[31]};
  assign rem_ge_d = (rem_sh_d >= {1'b0, g_q});
  assign rem_d    = rem_ge_d ? 32'(rem_sh_d - {1'b0, g_q}) : rem_sh_d[31:0];
  assign quo_d    = {quo_q[30:0], rem_ge_d};

  // Shift-and-add step: add the shifted multiplicand for each set multiplier bit.
  assign prod_d = prod_q + (mplier_q[0] ? mcand_q : 64'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      g_q       <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      result_q  <= '0;
      ready_n_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          a_q <= ina;
          b_q <= inb;
          if (ina == '0 || inb == '0) begin
            result_q  <= '0;
            ready_n_q <= 1'b0;
            state_q   <= ST_DONE;
          end else begin
            state_q <= ST_GCD;
          end
        end

        ST_GCD: begin
          if (!gcd_done_n) begin
            g_q     <= gcd_val;
            quo_q   <= a_q;
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_DIV;
          end
        end

        ST_DIV: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            mcand_q  <= {32'd0, quo_d};
            mplier_q <= b_q;
            prod_q   <= '0;
            state_q  <= ST_MUL;
          end
        end

        ST_MUL: begin
          prod_q   <= prod_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_q  <= prod_d;
            ready_n_q <= 1'b0;
            state_q   <= ST_DONE;
          end
        end

        ST_DONE: begin
          state_q <= ST_DONE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign result  = result_q;
  assign ready_n = ready_n_q;

endmodule

// File: tb/tb_lcm_32.sv
module tb_lcm_32;

  logic        clk;
  logic        rst;
  logic [31:0] ina;
  logic [31:0] inb;
  logic [63:0] result;
  logic        ready_n;

  int total;
  int bad;

  lcm_32 dut (
    .clk     (clk),
    .rst     (rst),
    .ina     (ina),
    .inb     (inb),
    .result  (result),
    .ready_n (ready_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply operands, hold reset for two edges, check the reset outputs, release.
  task automatic do_reset(input string tag, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    rst = 1'b1;
    ina = a;
    inb = b;
    @(negedge clk);
    @(negedge clk);
    chk_eq({tag, "_rst_res"}, result, 64'd0);
    chk_eq({tag, "_rst_rdy"}, {63'd0, ready_n}, 64'd1);
    rst = 1'b0;
  endtask

  // Wait (bounded) for ready_n to fall; result must read 0 while busy.
  task automatic wait_done(input string tag, input int lim);
    int n;
    n = 0;
    while (n < lim) begin
      @(negedge clk);
      n++;
      if (ready_n === 1'b0) break;
      if (result !== 64'd0) chk_eq({tag, "_busy_res"}, result, 64'd0);
    end
    chk_eq({tag, "_latency_ok"}, {63'd0, (ready_n === 1'b0)}, 64'd1);
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp, input int lim);
    do_reset(tag, a, b);
    wait_done(tag, lim);
    chk_eq({tag, "_res"}, result, exp);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    ina   = '0;
    inb   = '0;

    run("l640_120",  32'd640,        32'd120,        64'd1920,   256);
    run("l2502_122", 32'd2502,       32'd122,        64'd152622, 256);
    run("l1402_291", 32'd1402,       32'd291,        64'd407982, 256);
    run("lmax",      32'hFFFF_FFFF,  32'hFFFF_FFFE,  64'hFFFF_FFFD_0000_0002, 256);
    run("lmaxsame",  32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF, 256);
    run("lpow2",     32'h8000_0000,  32'h4000_0000,  64'h0000_0000_8000_0000, 256);
    run("lequal",    32'd12,         32'd12,         64'd12,     256);
    run("lones",     32'd1,          32'd1,          64'd1,      256);
    run("lzero_a",   32'd0,          32'd5,          64'd0,      2);
    chk_eq("lzero_a_rdy", {63'd0, ready_n}, 64'd0);
    run("lzero_b",   32'd9,          32'd0,          64'd0,      2);

    // Result must survive operand changes while done.
    run("lhold", 32'd6, 32'd4, 64'd12, 256);
    ina = 32'd1000;
    inb = 32'd3;
    repeat (10) @(negedge clk);
    chk_eq("hold_res", result, 64'd12);
    chk_eq("hold_rdy", {63'd0, ready_n}, 64'd0);

    // Reset in the middle of the GCD phase with new operands.
    do_reset("abort", 32'd640, 32'd120);
    repeat (4) @(negedge clk);
    chk_eq("abort_busy_rdy", {63'd0, ready_n}, 64'd1);
    chk_eq("abort_busy_res", result, 64'd0);
    rst = 1'b1;
    ina = 32'd7;
    inb = 32'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_eq("abort_rst_res", result, 64'd0);
      chk_eq("abort_rst_rdy", {63'd0, ready_n}, 64'd1);
    end
    rst = 1'b0;
    wait_done("abort", 256);
    chk_eq("abort_res", result, 64'd35);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
